// File: rtl/approx_mult_seq_if.sv
// approx_mult_seq_if: start/done handshake, operands and result of approx_mult_seq
interface approx_mult_seq_if #(parameter int WIDTH = 16);
  logic                 start;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  modport master (output start, a_in, b_in, input busy, done, result);
  modport slave  (input start, a_in, b_in, output busy, done, result);
endinterface

// File: rtl/approx_mult_seq.sv
// approx_mult_seq: sequential leading-one-normalised approximate multiplier with start/done control.
// Define APPROX_MULT_ROUND_EN to round each kept field to nearest instead of truncating.
module approx_mult_seq #(
  parameter int WIDTH = 16,
  parameter int KEEP  = 8
) (
  input logic               clk,
  input logic               rst,
  approx_mult_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(2*WIDTH-1);
  localparam int SH    = 2*WIDTH-2*KEEP;
  localparam int RB    = (KEEP < WIDTH) ? WIDTH-KEEP-1 : 0;
  typedef enum logic [2:0] {IDLE, ZERO, NORM, MULT, DENORM, DONE} state_t;
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_res;
  logic [KEEP-1:0]    w_ak, w_bk;
  logic [2*KEEP-1:0]  w_p;
`ifdef APPROX_MULT_ROUND_EN
  logic [KEEP:0]      w_ar, w_br;
  // Round bit only exists when some low bits are discarded; a carry out saturates.
  assign w_ar = {1'b0, r_a[WIDTH-1 -: KEEP]} + (KEEP+1)'((KEEP < WIDTH) & r_a[RB]);
  assign w_br = {1'b0, r_b[WIDTH-1 -: KEEP]} + (KEEP+1)'((KEEP < WIDTH) & r_b[RB]);
  assign w_ak = w_ar[KEEP] ? '1 : w_ar[KEEP-1:0];
  assign w_bk = w_br[KEEP] ? '1 : w_br[KEEP-1:0];
`else
  assign w_ak = r_a[WIDTH-1 -: KEEP];
  assign w_bk = r_b[WIDTH-1 -: KEEP];
`endif
  assign w_p = (2*KEEP)'(w_ak) * (2*KEEP)'(w_bk);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = (bus.a_in == '0 || bus.b_in == '0) ? ZERO : NORM;
      ZERO:    w_next = DONE;
      NORM:    w_next = (r_a[WIDTH-1] & r_b[WIDTH-1]) ? MULT : NORM;
      MULT:    w_next = DENORM;
      DENORM:  w_next = (r_cnt == '0) ? DONE : DENORM;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (bus.start) begin
          r_a   <= bus.a_in;
          r_b   <= bus.b_in;
          r_cnt <= '0;
        end
        ZERO: r_res <= '0;
        NORM: begin
          if (!r_a[WIDTH-1]) r_a <= r_a << 1;
          if (!r_b[WIDTH-1]) r_b <= r_b << 1;
          r_cnt <= r_cnt + CNT_W'(!r_a[WIDTH-1]) + CNT_W'(!r_b[WIDTH-1]);
        end
        MULT: r_res <= (2*WIDTH)'(w_p) << SH;
        DENORM: if (r_cnt != '0) begin
          r_res <= r_res >> 1;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = (r_state == DONE);
  assign bus.result = r_res;
endmodule
